// File: rtl/block_compactor_pkg.sv
// Shared types and helpers for the block compactor: block type, count-width
// helper and the per-channel block-count clamp.
package block_compactor_pkg;

  localparam int DEF_BLOCK_SIZE = 64;

  typedef logic [DEF_BLOCK_SIZE-1:0] block_t;

  // Bits needed to hold a count in the range 0..n.
  function automatic int clog2_cnt(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int sat_num(input int num, input int max_num);
    return (num > max_num) ? max_num : num;
  endfunction

endpackage

// File: rtl/block_compactor_if.sv
// Stream bundle of the block compactor: multi-channel block input side and
// dense word output side, each with a valid/ready handshake.
interface block_compactor_if
  import block_compactor_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_IN     = 2,
  parameter int IN_BLOCKS  = 4,
  parameter int OUT_BLOCKS = 8
);
  localparam int NW_IN  = clog2_cnt(IN_BLOCKS);
  localparam int NW_OUT = clog2_cnt(OUT_BLOCKS);

  logic [NUM_IN-1:0]                                in_ready;
  logic [NUM_IN-1:0]                                in_valid;
  logic [NUM_IN-1:0][IN_BLOCKS-1:0][BLOCK_SIZE-1:0] in_data;
  logic [NUM_IN-1:0][NW_IN-1:0]                     in_num;
  logic [NUM_IN-1:0]                                in_last;
  logic                                             out_ready;
  logic                                             out_valid;
  logic [OUT_BLOCKS-1:0][BLOCK_SIZE-1:0]            out_data;
  logic [NW_OUT-1:0]                                out_num;
  logic                                             out_last;
  logic                                             err;

  modport master (
    input  in_ready, out_valid, out_data, out_num, out_last, err,
    output in_valid, in_data, in_num, in_last, out_ready
  );

  modport slave (
    output in_ready, out_valid, out_data, out_num, out_last, err,
    input  in_valid, in_data, in_num, in_last, out_ready
  );

endinterface

// File: rtl/block_compactor_packer.sv
// Combinational packer: gathers the valid blocks of all channels into one
// contiguous vector (ch0 first) with the total count and an over-range flag.
module block_compactor_packer
  import block_compactor_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_IN     = 2,
  parameter int IN_BLOCKS  = 4,
  localparam int NW_IN     = clog2_cnt(IN_BLOCKS),
  localparam int NW_TOT    = clog2_cnt(NUM_IN * IN_BLOCKS),
  localparam int TOT_W     = NUM_IN * IN_BLOCKS * BLOCK_SIZE
) (
  input  logic [NUM_IN-1:0]                                valid,
  input  logic [NUM_IN-1:0][IN_BLOCKS-1:0][BLOCK_SIZE-1:0] data,
  input  logic [NUM_IN-1:0][NW_IN-1:0]                     num,
  output logic [TOT_W-1:0]                                 blocks,
  output logic [NW_TOT-1:0]                                total,
  output logic                                             over
);
  localparam int CH_W = IN_BLOCKS * BLOCK_SIZE;

  logic [NW_IN-1:0]  cnt;
  logic [NW_TOT-1:0] offset;
  logic [CH_W-1:0]   chunk;

  // NOTE: every variable gets a value before any branch so no latch is inferred.
  always_comb begin
    blocks = '0;
    over   = 1'b0;
    offset = '0;
    cnt    = '0;
    chunk  = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      cnt   = '0;
      chunk = '0;
      if (valid[c]) begin
        cnt = NW_IN'(sat_num(int'(num[c]), IN_BLOCKS));
        if (num[c] > NW_IN'(IN_BLOCKS)) over = 1'b1;
      end
      for (int i = 0; i < IN_BLOCKS; i++) begin
        if (NW_IN'(i) < cnt) chunk[i*BLOCK_SIZE +: BLOCK_SIZE] = data[c][i];
      end
      // The running prefix sum places this channel right after the previous ones.
      blocks = blocks | (TOT_W'(chunk) << (offset * BLOCK_SIZE));
      offset = offset + NW_TOT'(cnt);
    end
    total = offset;
  end

endmodule

// File: rtl/block_compactor.sv
// Block compactor: merges per-channel block beats into dense OUT_BLOCKS-wide
// words through a residue buffer; the last word of a frame is flushed partial.
module block_compactor
  import block_compactor_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_IN     = 2,
  parameter int IN_BLOCKS  = 4,
  parameter int OUT_BLOCKS = 8
) (
  input logic              clk,
  input logic              rst,
  block_compactor_if.slave bus
);
  localparam int TOT_BLOCKS = NUM_IN * IN_BLOCKS;
  localparam int BUF_BLOCKS = OUT_BLOCKS + TOT_BLOCKS;
  localparam int NW_TOT     = clog2_cnt(TOT_BLOCKS);
  localparam int NW_OUT     = clog2_cnt(OUT_BLOCKS);
  localparam int NW_BUF     = clog2_cnt(BUF_BLOCKS);
  localparam int TOT_W      = TOT_BLOCKS * BLOCK_SIZE;
  localparam int BUF_W      = BUF_BLOCKS * BLOCK_SIZE;
  localparam int OUT_W      = OUT_BLOCKS * BLOCK_SIZE;

  logic [BUF_W-1:0]  residue, residue_next;
  logic [NW_BUF-1:0] fill, fill_next, fill_base, emit_cnt, acc_cnt;
  logic              flush_pending, err_q;
  logic              out_valid_q, out_last_q;
  logic [OUT_W-1:0]  out_data_q;
  logic [NW_OUT-1:0] out_num_q;
  logic [TOT_W-1:0]  pk_blocks;
  logic [NW_TOT-1:0] pk_total;
  logic              pk_over;
  logic              fill_full, ready_all, accept, emit, frame_end, last_word;

  block_compactor_packer #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .NUM_IN     (NUM_IN),
    .IN_BLOCKS  (IN_BLOCKS)
  ) u_packer (
    .valid  (bus.in_valid),
    .data   (bus.in_data),
    .num    (bus.in_num),
    .blocks (pk_blocks),
    .total  (pk_total),
    .over   (pk_over)
  );

  always_comb begin
    fill_full = (fill >= NW_BUF'(OUT_BLOCKS));
    ready_all = !fill_full && !flush_pending;
    accept    = ready_all && (|bus.in_valid);
    frame_end = |(bus.in_valid & bus.in_last);
    emit      = (!out_valid_q || bus.out_ready) && (fill_full || flush_pending);
    last_word = flush_pending && (fill <= NW_BUF'(OUT_BLOCKS));
    emit_cnt  = '0;
    if (emit) emit_cnt = fill_full ? NW_BUF'(OUT_BLOCKS) : fill;
    acc_cnt   = accept ? NW_BUF'(pk_total) : '0;
    fill_base = fill - emit_cnt;
    fill_next = fill_base + acc_cnt;
    // Shift out the emitted blocks first, then append the new beat above what remains.
    residue_next = residue >> (emit_cnt * BLOCK_SIZE);
    if (accept) residue_next = residue_next | (BUF_W'(pk_blocks) << (fill_base * BLOCK_SIZE));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the residue is cleared because blocks above fill must read as zero:
      // appends OR into that region and unused output lanes are taken from it.
      residue       <= '0;
      fill          <= '0;
      flush_pending <= 1'b0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_num_q     <= '0;
      out_last_q    <= 1'b0;
    end else begin
      residue <= residue_next;
      fill    <= fill_next;
      if (emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= residue[OUT_W-1:0];
        out_num_q   <= NW_OUT'(emit_cnt);
        out_last_q  <= last_word;
        if (last_word) flush_pending <= 1'b0;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && frame_end) flush_pending <= 1'b1;
      if (accept && pk_over)   err_q         <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (fill <= NW_BUF'(BUF_BLOCKS));
  end

  assign bus.in_ready  = {NUM_IN{ready_all}};
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_num   = out_num_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_block_compactor.sv
// Self-checking bench for block_compactor: a table of single-beat frames plus
// hand-written sequences for carry-over, backpressure, clamping and reset.
module tb_block_compactor;
  import block_compactor_pkg::*;

  localparam int BS = 64;
  localparam int NI = 2;
  localparam int IB = 4;
  localparam int OB = 8;
  localparam int NV = 7;

  typedef logic [511:0] cv_t;

  typedef struct {
    logic [1:0] vld;
    logic [1:0] lst;
    logic [2:0] n0;
    logic [2:0] n1;
    int         exp_num;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  block_compactor_if #(.BLOCK_SIZE(BS), .NUM_IN(NI), .IN_BLOCKS(IB), .OUT_BLOCKS(OB)) bus ();

  block_compactor #(.BLOCK_SIZE(BS), .NUM_IN(NI), .IN_BLOCKS(IB), .OUT_BLOCKS(OB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input cv_t act, input cv_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic block_t mk_blk(input int tag, input int c, input int i);
    return {8'hB0, tag[7:0], c[7:0], i[7:0], 32'h0123_4567};
  endfunction

  function automatic block_t seq_blk(input int n);
    return {32'h5E00_0000, n[31:0]};
  endfunction

  // Expected dense word for one beat: valid channels in order, unused lanes zero.
  function automatic cv_t exp_word(input logic [1:0] vld, input int n0, input int n1, input int tag);
    cv_t w = '0;
    int  lane = 0;
    if (vld[0]) for (int i = 0; i < n0; i++) begin w[lane*BS +: BS] = mk_blk(tag, 0, i); lane++; end
    if (vld[1]) for (int i = 0; i < n1; i++) begin w[lane*BS +: BS] = mk_blk(tag, 1, i); lane++; end
    return w;
  endfunction

  task automatic clear_in();
    bus.in_valid = '0;
    bus.in_last  = '0;
    bus.in_num   = '0;
    bus.in_data  = '0;
  endtask

  // Data is filled on every lane so that blocks beyond in_num must be masked.
  task automatic drive_beat(input logic [1:0] vld, input logic [1:0] lst,
                            input logic [2:0] n0, input logic [2:0] n1, input int tag);
    for (int c = 0; c < NI; c++)
      for (int i = 0; i < IB; i++) bus.in_data[c][i] = mk_blk(tag, c, i);
    bus.in_valid  = vld;
    bus.in_last   = lst;
    bus.in_num[0] = n0;
    bus.in_num[1] = n1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.in_ready[0] && n < 20) begin step(); n++; end
    if (!bus.in_ready[0]) check({name, " ready timeout"}, cv_t'(bus.in_ready[0]), cv_t'(1'b1));
  endtask

  task automatic wait_out(input string name, output bit got);
    int n = 0;
    while (!bus.out_valid && n < 20) begin step(); n++; end
    got = bus.out_valid;
    check({name, " out_valid"}, cv_t'(bus.out_valid), cv_t'(1'b1));
  endtask

  vec_t vecs [NV];
  bit   got, held, extra;
  int   seq, got_cnt;
  cv_t  hold_data;
  logic [3:0] hold_num;
  logic       hold_last;

  initial begin
    // {valid, last, ch0 num, ch1 num, expected out_num}; every vector is a one-beat frame.
    vecs[0] = '{2'b11, 2'b01, 3'd3, 3'd4, 7};
    vecs[1] = '{2'b01, 2'b01, 3'd4, 3'd0, 4};
    vecs[2] = '{2'b10, 2'b10, 3'd0, 3'd2, 2};
    vecs[3] = '{2'b11, 2'b10, 3'd4, 3'd4, 8};
    vecs[4] = '{2'b01, 2'b01, 3'd0, 3'd0, 0};
    vecs[5] = '{2'b10, 2'b10, 3'd3, 3'd1, 1};
    vecs[6] = '{2'b11, 2'b11, 3'd1, 3'd0, 1};

    rst = 1'b1;
    clear_in();
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset out_valid", cv_t'(bus.out_valid), cv_t'(1'b0));
    check("reset out_num",   cv_t'(bus.out_num),   cv_t'(4'd0));
    check("reset out_last",  cv_t'(bus.out_last),  cv_t'(1'b0));
    check("reset out_data",  cv_t'(bus.out_data),  cv_t'(0));
    check("reset err",       cv_t'(bus.err),       cv_t'(1'b0));
    check("reset in_ready",  cv_t'(bus.in_ready),  cv_t'(2'b11));

    // Carry-over of one block into the next word, then a partial last word.
    drive_beat(2'b11, 2'b00, 3'd3, 3'd4, 1);
    step();
    drive_beat(2'b01, 2'b00, 3'd2, 3'd3, 2);
    check("t1 ready beat2", cv_t'(bus.in_ready), cv_t'(2'b11));
    step();
    clear_in();
    wait_out("t1", got);
    if (got) begin
      check("t1 num",  cv_t'(bus.out_num),  cv_t'(4'd8));
      check("t1 last", cv_t'(bus.out_last), cv_t'(1'b0));
      check("t1 data", cv_t'(bus.out_data),
            {mk_blk(2, 0, 0), mk_blk(1, 1, 3), mk_blk(1, 1, 2), mk_blk(1, 1, 1),
             mk_blk(1, 1, 0), mk_blk(1, 0, 2), mk_blk(1, 0, 1), mk_blk(1, 0, 0)});
    end
    check("t1 ready after word", cv_t'(bus.in_ready), cv_t'(2'b11));
    drive_beat(2'b10, 2'b10, 3'd0, 3'd1, 3);
    step();
    clear_in();
    check("t2 ready while flushing", cv_t'(bus.in_ready), cv_t'(2'b00));
    wait_out("t2", got);
    if (got) begin
      check("t2 num",  cv_t'(bus.out_num),  cv_t'(4'd2));
      check("t2 last", cv_t'(bus.out_last), cv_t'(1'b1));
      check("t2 data", cv_t'(bus.out_data), cv_t'({mk_blk(3, 1, 0), mk_blk(2, 0, 1)}));
    end
    step();
    check("t2 out_valid drop", cv_t'(bus.out_valid), cv_t'(1'b0));
    check("t2 ready again",    cv_t'(bus.in_ready),  cv_t'(2'b11));

    for (int k = 0; k < NV; k++) begin
      wait_ready($sformatf("v%0d", k));
      drive_beat(vecs[k].vld, vecs[k].lst, vecs[k].n0, vecs[k].n1, 16 + k);
      step();
      clear_in();
      wait_out($sformatf("v%0d", k), got);
      if (got) begin
        check($sformatf("v%0d num", k),  cv_t'(bus.out_num),  cv_t'(vecs[k].exp_num));
        check($sformatf("v%0d last", k), cv_t'(bus.out_last), cv_t'(1'b1));
        check($sformatf("v%0d data", k), cv_t'(bus.out_data),
              exp_word(vecs[k].vld, int'(vecs[k].n0), int'(vecs[k].n1), 16 + k));
      end
      step();
      check($sformatf("v%0d single word", k), cv_t'(bus.out_valid), cv_t'(1'b0));
    end

    // Backpressure: full beats offered every cycle while the output is stalled.
    bus.out_ready = 1'b0;
    seq  = 0;
    held = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      for (int c = 0; c < NI; c++)
        for (int i = 0; i < IB; i++) bus.in_data[c][i] = seq_blk(seq + c * IB + i);
      bus.in_valid  = 2'b11;
      bus.in_last   = 2'b00;
      bus.in_num[0] = 3'd4;
      bus.in_num[1] = 3'd4;
      got = bus.in_ready[0];
      if (held) begin
        check($sformatf("t3 hold valid c%0d", cyc), cv_t'(bus.out_valid), cv_t'(1'b1));
        check($sformatf("t3 hold data c%0d", cyc),  cv_t'(bus.out_data),  hold_data);
        check($sformatf("t3 hold num c%0d", cyc),   cv_t'({bus.out_last, bus.out_num}),
              cv_t'({hold_last, hold_num}));
      end else if (bus.out_valid) begin
        held      = 1'b1;
        hold_data = cv_t'(bus.out_data);
        hold_num  = bus.out_num;
        hold_last = bus.out_last;
      end
      step();
      if (got) seq += 8;
    end
    clear_in();
    check("t3 in_ready low", cv_t'(bus.in_ready), cv_t'(2'b00));
    check("t3 accepted",     cv_t'(seq),          cv_t'(16));
    bus.out_ready = 1'b1;
    got_cnt = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (bus.out_valid) begin
        for (int lane = 0; lane < int'(bus.out_num); lane++) begin
          check($sformatf("t3 block %0d", got_cnt), cv_t'(bus.out_data[lane]), cv_t'(seq_blk(got_cnt)));
          got_cnt++;
        end
      end
      step();
    end
    check("t3 block count", cv_t'(got_cnt), cv_t'(16));

    // Over-range count is clamped and latches err.
    wait_ready("t5");
    drive_beat(2'b01, 2'b01, 3'd7, 3'd0, 5);
    check("t5 err before", cv_t'(bus.err), cv_t'(1'b0));
    step();
    clear_in();
    check("t5 err set", cv_t'(bus.err), cv_t'(1'b1));
    wait_out("t5", got);
    if (got) begin
      check("t5 num",  cv_t'(bus.out_num),  cv_t'(4'd4));
      check("t5 last", cv_t'(bus.out_last), cv_t'(1'b1));
      check("t5 data", cv_t'(bus.out_data), exp_word(2'b01, 4, 0, 5));
    end
    for (int n = 0; n < 4; n++) step();
    check("t5 err sticky", cv_t'(bus.err), cv_t'(1'b1));

    // Reset mid-frame with residue and a pending flush.
    bus.out_ready = 1'b0;
    drive_beat(2'b11, 2'b00, 3'd4, 3'd4, 30);
    step();
    clear_in();
    step();
    drive_beat(2'b11, 2'b01, 3'd4, 3'd1, 31);
    step();
    clear_in();
    check("t6 pre held", cv_t'(bus.out_valid), cv_t'(1'b1));
    check("t6 pre ready", cv_t'(bus.in_ready), cv_t'(2'b00));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6 out_valid", cv_t'(bus.out_valid), cv_t'(1'b0));
    check("t6 err",       cv_t'(bus.err),       cv_t'(1'b0));
    check("t6 in_ready",  cv_t'(bus.in_ready),  cv_t'(2'b11));
    bus.out_ready = 1'b1;
    drive_beat(2'b11, 2'b00, 3'd4, 3'd4, 32);
    step();
    clear_in();
    wait_out("t6", got);
    if (got) begin
      check("t6 num",  cv_t'(bus.out_num),  cv_t'(4'd8));
      check("t6 last", cv_t'(bus.out_last), cv_t'(1'b0));
      check("t6 data", cv_t'(bus.out_data), exp_word(2'b11, 4, 4, 32));
    end
    extra = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      extra |= bus.out_valid;
    end
    check("t6 no old residue", cv_t'(extra), cv_t'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
